// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

  // A toggle whose new level differs from cpol is a leading edge; otherwise trailing.
  function automatic logic edge_sel(input spi_mode_t m, input logic level,
                                    input logic toggled, input logic want_sample);
    logic lead;
    logic trail;
    lead  = toggled & (level ^ m.cpol);
    trail = toggled & ~(level ^ m.cpol);
    if (want_sample) return m.cpha ? trail : lead;
    else             return m.cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// RX/TX word streams between the SPI slave and the internal logic.
interface spi_slave_param_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall detection.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_sr;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr <= {STAGES{RST_VAL}};
      q_d     <= RST_VAL;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      q_d     <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/spi_slave_param.sv
// Full-duplex SPI slave, all four modes, oversampled on clk with valid/ready word streams.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs_n,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic             cpol,
  input  logic             cpha,
  spi_slave_param_if.slave strm,
  output logic             busy,
  output logic             rx_overrun,
  output logic             tx_underrun,
  input  logic             clr_status
);
  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  spi_mode_t         mode;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-2:0] rx_sr, rx_sr_next;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_sr, tx_next;
  logic en, sample, shift, word_done, rx_load, tx_load;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk, .rst, .d(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk, .rst, .d(spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  // sclk edges count only inside a frame and never on the frame-start clk.
  assign en        = ~cs_q & ~cs_fall;
  assign sample    = en & edge_sel(mode, sclk_q, sclk_rise | sclk_fall, 1'b1);
  assign shift     = en & edge_sel(mode, sclk_q, sclk_rise | sclk_fall, 1'b0);
  assign word_done = sample & (cnt == CNT_LAST);
  assign rx_load   = word_done & (~strm.rx_valid | strm.rx_ready);
  assign tx_load   = (cs_fall & ~cpha) | (shift & (cnt == '0));
  assign busy      = ~cs_q;

  always_comb begin
    rx_word    = MSB_FIRST ? {rx_sr, mosi_q} : {mosi_q, rx_sr};
    rx_sr_next = rx_sr;
    cnt_next   = cnt;
    tx_next    = tx_sr;
    if (cs_rise) begin
      cnt_next   = '0;
      rx_sr_next = '0;
    end else if (cs_fall) begin
      cnt_next = '0;
    end else if (sample) begin
      rx_sr_next = MSB_FIRST ? rx_word[DATA_W-2:0] : rx_word[DATA_W-1:1];
      cnt_next   = word_done ? '0 : cnt + 1'b1;
    end
    if (tx_load)
      tx_next = strm.tx_valid ? strm.tx_data : '0;
    else if (shift)
      tx_next = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    if (cs_rise)
      tx_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode          <= SPI_MODE0;
      cnt           <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      spi_miso      <= 1'b0;
      strm.rx_data  <= '0;
      strm.rx_valid <= 1'b0;
      strm.tx_ready <= 1'b0;
      rx_overrun    <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      if (cs_fall) mode <= '{cpol, cpha};
      cnt      <= cnt_next;
      rx_sr    <= rx_sr_next;
      tx_sr    <= tx_next;
      spi_miso <= ~cs_q & (MSB_FIRST ? tx_next[DATA_W-1] : tx_next[0]);

      if (rx_load) begin
        strm.rx_data  <= rx_word;
        strm.rx_valid <= 1'b1;
      end else if (strm.rx_valid & strm.rx_ready) begin
        strm.rx_valid <= 1'b0;
      end
      strm.tx_ready <= tx_load & strm.tx_valid;

      if (word_done & ~rx_load) rx_overrun <= 1'b1;
      else if (clr_status)      rx_overrun <= 1'b0;
      if (tx_load & ~strm.tx_valid) tx_underrun <= 1'b1;
      else if (clr_status)          tx_underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench: an 8-bit MSB-first and a 12-bit LSB-first slave driven by a behavioural SPI master.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int HP = 4;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic cs8 = 1'b1, cs12 = 1'b1, sclk = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic miso8, miso12, busy8, busy12, ovr8, unr8, ovr12, unr12;

  spi_slave_param_if #(.DATA_W(8))  b8 ();
  spi_slave_param_if #(.DATA_W(12)) b12 ();

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .spi_cs_n(cs8), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso8), .cpol(cpol), .cpha(cpha), .strm(b8), .busy(busy8),
    .rx_overrun(ovr8), .tx_underrun(unr8), .clr_status(clr)
  );

  spi_slave_param #(.DATA_W(12), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .rst(rst), .spi_cs_n(cs12), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso12), .cpol(cpol), .cpha(cpha), .strm(b12), .busy(busy12),
    .rx_overrun(ovr12), .tx_underrun(unr12), .clr_status(clr)
  );

  int total = 0, bad = 0, txr8 = 0, txr12 = 0;
  logic [31:0] exp8[$], exp12[$], txq8[$], txq12[$], wq[$];
  bit exp_unr[2], exp_ovr[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RX scoreboard monitors
  initial forever begin
    @(negedge clk);
    if (b8.rx_valid === 1'b1 && b8.rx_ready === 1'b1) begin
      if (exp8.size() == 0) begin
        total++; bad++;
        $display("FAIL rx8_unexpected: got %0h want none", b8.rx_data);
      end else check("rx8_word", 32'(b8.rx_data), exp8.pop_front());
    end
    if (b12.rx_valid === 1'b1 && b12.rx_ready === 1'b1) begin
      if (exp12.size() == 0) begin
        total++; bad++;
        $display("FAIL rx12_unexpected: got %0h want none", b12.rx_data);
      end else check("rx12_word", 32'(b12.rx_data), exp12.pop_front());
    end
  end

  // TX producers: present the head of each queue, pop on tx_ready
  initial begin
    b8.tx_valid = 1'b0;  b8.tx_data = '0;
    b12.tx_valid = 1'b0; b12.tx_data = '0;
    forever begin
      @(posedge clk); #1;
      if (b8.tx_ready === 1'b1) begin
        txr8++;
        if (txq8.size() > 0) void'(txq8.pop_front());
      end
      if (b12.tx_ready === 1'b1) begin
        txr12++;
        if (txq12.size() > 0) void'(txq12.pop_front());
      end
      b8.tx_valid  = (txq8.size() > 0);
      b8.tx_data   = (txq8.size() > 0) ? txq8[0][7:0] : 8'h0;
      b12.tx_valid = (txq12.size() > 0);
      b12.tx_data  = (txq12.size() > 0) ? txq12[0][11:0] : 12'h0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic miso_of(input int sel);
    return sel ? miso12 : miso8;
  endfunction

  task automatic set_cs(input int sel, input logic v);
    if (sel) cs12 = v; else cs8 = v;
  endtask

  task automatic clr_pulse();
    clr = 1'b1; clks(1); clr = 1'b0;
    exp_unr[0] = 0; exp_unr[1] = 0; exp_ovr[0] = 0; exp_ovr[1] = 0;
  endtask

  task automatic begin_frame(input int sel, input logic [1:0] md);
    cpol = md[1]; cpha = md[0]; sclk = md[1];
    clks(4); set_cs(sel, 1'b0); clks(8);
  endtask

  task automatic end_frame(input int sel);
    clks(8); set_cs(sel, 1'b1); clks(8);
  endtask

  // Master: drive on shift edges, sample MISO just before each sample edge
  task automatic xfer(input int sel, input logic [31:0] word, input int nb, input int w,
                      input bit lsb, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < nb; i++) begin
      int idx;
      idx = lsb ? i : w - 1 - i;
      if (!cpha) begin
        mosi = word[idx]; clks(HP);
        got[idx] = miso_of(sel);
        sclk = ~sclk; clks(HP);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk; mosi = word[idx]; clks(HP);
        got[idx] = miso_of(sel);
        sclk = ~sclk; clks(HP);
      end
    end
  endtask

  // One frame of wq words; npush of them are expected to reach rx_data
  task automatic run_frame(input int sel, input logic [1:0] md, input int npush);
    int n, avail, loads, p0, expp;
    logic [31:0] expm[$];
    logic [31:0] got;
    n = wq.size();
    avail = sel ? txq12.size() : txq8.size();
    for (int i = 0; i < n; i++)
      expm.push_back(i < avail ? (sel ? txq12[i] : txq8[i]) : 32'h0);
    loads = n + (md[0] ? 0 : 1);
    p0 = sel ? txr12 : txr8;
    for (int i = 0; i < npush; i++)
      if (sel) exp12.push_back(wq[i]); else exp8.push_back(wq[i]);
    begin_frame(sel, md);
    for (int i = 0; i < n; i++) begin
      xfer(sel, wq[i], sel ? 12 : 8, sel ? 12 : 8, sel != 0, got);
      check(sel ? "miso12_word" : "miso8_word", got, expm[i]);
    end
    end_frame(sel);
    expp = (loads < avail) ? loads : avail;
    check("tx_ready_pulses", (sel ? txr12 : txr8) - p0, expp);
    if (loads > avail) exp_unr[sel] = 1;
    if (npush < n) exp_ovr[sel] = 1;
    check("tx_underrun", sel ? unr12 : unr8, exp_unr[sel]);
    check("rx_overrun", sel ? ovr12 : ovr8, exp_ovr[sel]);
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0] modes[3];
    b8.rx_ready = 1'b1; b12.rx_ready = 1'b1;
    clks(4);
    check("rst_out8", {b8.rx_data, b8.rx_valid, b8.tx_ready, miso8, busy8, ovr8, unr8}, 0);
    check("rst_out12", {b12.rx_data, b12.rx_valid, b12.tx_ready, miso12, busy12, ovr12, unr12}, 0);
    rst = 1'b0; clks(4);

    // mode 0 single word
    txq8.push_back(32'h3C); clks(3);
    wq = {}; wq.push_back(32'hA5);
    run_frame(0, SPI_MODE0, 1);
    check("rx8_data_a5", 32'(b8.rx_data), 32'hA5);
    clr_pulse();

    // modes 1..3, two words per frame
    modes[0] = SPI_MODE1; modes[1] = SPI_MODE2; modes[2] = SPI_MODE3;
    for (int m = 0; m < 3; m++) begin
      txq8.push_back(32'hF0); txq8.push_back(32'h0F); clks(3);
      wq = {}; wq.push_back(32'h81); wq.push_back(32'h7E);
      run_frame(0, modes[m], 2);
      clr_pulse();
    end

    // overrun with rx_ready low
    b8.rx_ready = 1'b0;
    wq = {}; wq.push_back(32'h11); wq.push_back(32'h22); wq.push_back(32'h33);
    run_frame(0, SPI_MODE0, 1);
    check("ovr_held_data", 32'(b8.rx_data), 32'h11);
    check("ovr_held_valid", 32'(b8.rx_valid), 1);
    clr_pulse();
    check("ovr_cleared", 32'(ovr8), 0);
    b8.rx_ready = 1'b1; clks(4);
    check("rx8_drained", exp8.size(), 0);

    // underrun, then clear coinciding with a new underrun
    wq = {}; wq.push_back(32'h3A);
    run_frame(0, SPI_MODE0, 1);
    clr_pulse();
    check("unr_cleared", 32'(unr8), 0);
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; clks(4);
    cs8 = 1'b0; clks(2);
    clr = 1'b1; clks(1); clr = 1'b0;
    check("unr_set_beats_clr", 32'(unr8), 1);
    clks(4); cs8 = 1'b1; clks(8);
    clr_pulse();

    // partial word discarded, next frame clean
    begin_frame(0, SPI_MODE0);
    xfer(0, 32'hC7, 5, 8, 0, got);
    end_frame(0);
    exp_unr[0] = 1;
    wq = {}; wq.push_back(32'h55);
    run_frame(0, SPI_MODE0, 1);
    check("rx8_after_partial", 32'(b8.rx_data), 32'h55);
    clr_pulse();

    // 12-bit LSB-first, then reset mid-word
    txq12.push_back(32'h5A1); clks(3);
    wq = {}; wq.push_back(32'h9C3);
    run_frame(1, SPI_MODE0, 1);
    check("rx12_data_9c3", 32'(b12.rx_data), 32'h9C3);
    clr_pulse();
    begin_frame(1, SPI_MODE0);
    xfer(1, 32'h3F0, 6, 12, 1, got);
    rst = 1'b1; clks(2);
    check("midrst_out12", {b12.rx_data, b12.rx_valid, b12.tx_ready, miso12, busy12, ovr12, unr12}, 0);
    cs12 = 1'b1; sclk = 1'b0; clks(3);
    rst = 1'b0; clks(4);
    check("postrst_busy12", 32'(busy12), 0);
    wq = {}; wq.push_back(32'h2B6);
    run_frame(1, SPI_MODE0, 1);
    check("rx12_after_rst", 32'(b12.rx_data), 32'h2B6);
    clr_pulse();

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      int sel, n, nt;
      logic [1:0] md;
      logic [31:0] mask;
      sel  = $urandom_range(0, 1);
      md   = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, 3);
      nt   = $urandom_range(0, 3);
      mask = sel ? 32'hFFF : 32'hFF;
      for (int k = 0; k < nt; k++)
        if (sel) txq12.push_back($urandom & mask); else txq8.push_back($urandom & mask);
      clks(3);
      wq = {};
      for (int k = 0; k < n; k++) wq.push_back($urandom & mask);
      run_frame(sel, md, n);
    end

    clks(4);
    check("final_rx8_empty", exp8.size(), 0);
    check("final_rx12_empty", exp12.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave and successor to the 8-bit receive-only SPI front end.
- Full duplex, configurable word width and bit order, all four SPI modes (CPOL/CPHA), valid/ready streams for RX and TX, sticky overrun/underrun status.
- Sits between the chip pins (through synchronisers) and the design's internal byte/word-stream logic. Everything runs on clk; SCLK is oversampled, never used as a clock.

Parameters:
- DATA_W, 8, word width in bits (2..32).
- MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- SYNC_STAGES, 2, flip-flop stages on cs_n, sclk and mosi (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_sclk  in  1  SPI clock, asynchronous.
- spi_mosi  in  1  SPI data in, asynchronous.
- spi_miso  out  1  SPI data out.
- cpol  in  1  clock polarity, captured at frame start.
- cpha  in  1  clock phase, captured at frame start.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data available.
- tx_ready  out  1  one-clk pulse: tx_data taken.
- busy  out  1  synced cs_n low (frame active).
- rx_overrun  out  1  sticky: a word was dropped.
- tx_underrun  out  1  sticky: zeros were sent because tx_valid was low.
- clr_status  in  1  one-clk pulse clears both sticky flags.

Behaviour:
- Reset: all outputs 0 (rx_data=0, rx_valid=0, tx_ready=0, spi_miso=0, busy=0, both flags=0); bit counter=0; shift registers=0; mode register=0.
- Synchronisers: cs_n, sclk and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the synced value with a one-flop delayed copy. cs_n resets to 1; sclk and mosi reset to 0.
- Frame start is a falling edge of synced cs_n. On this edge, cpol and cpha latch into the mode register and the bit counter clears. cpol/cpha changes mid-frame are ignored.
- Leading edge: rising sclk if cpol=0, falling if cpol=1. Trailing edge is the opposite.
- Sample edge: leading if cpha=0, trailing if cpha=1. Shift edge is the other one.
- sclk edges are ignored while synced cs_n=1.
- If an sclk edge and the cs_n rise land in the same clk, cs_n wins and the edge is ignored.
- Sample edge: the synced mosi bit enters the RX shift register (MSB_FIRST selects the shift direction), and the bit counter increments modulo DATA_W.
- Word complete, on the sample edge where the counter is DATA_W-1:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same clk: rx_data <= the full word including the new bit, and rx_valid=1 on the next clk.
  - Otherwise the word is dropped, rx_data is unchanged, and rx_overrun is set.
- rx_valid clears on rx_valid & rx_ready unless a new word loads in the same clk.
- TX load:
  - Load sources: frame start when cpha=0, and every shift edge with bit counter=0.
  - If tx_valid=1: TX shift register <= tx_data and tx_ready pulses for 1 clk.
  - Otherwise it loads 0 and tx_underrun is set.
  - A cpha=1 frame start does not load, so no word is consumed twice.
- A shift edge with bit counter !=0 shifts the TX register by one bit.
- spi_miso is the registered TX register end bit (MSB if MSB_FIRST, else LSB), forced to 0 while synced cs_n=1.
- Frame end is a rising edge of synced cs_n. A partial RX word is discarded, the counter clears, and the TX contents are discarded. A word already in rx_data is kept.
- clr_status clears both flags. If a set event occurs in the same clk, the set wins.
- Latency:
  - pin sclk edge to internal sample event: SYNC_STAGES+1 clk.
  - last sample to rx_valid: 1 clk.
- Timing limit: the sclk high and low phases must each be >= SYNC_STAGES+2 clk; behaviour outside this limit is unspecified.
- rst mid-frame returns everything to reset values. The block waits for the next cs_n falling edge.

Decomposition:
- Package spi_pkg:
  - spi_mode_t struct {cpol, cpha}.
  - SPI_MODE0..3 constants.
  - Helper function for leading/sample edge selection.
- Sub-module spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall detect. Instantiated for cs_n and sclk; mosi uses the synchroniser only.

Test Plan:
1. Mode 0, DATA_W=8, MSB_FIRST, clk:sclk 8:1. Send 0xA5 with tx_data=0x3C preloaded and rx_ready=1 -> rx_valid pulses with rx_data=0xA5, MISO bits read 0x3C, tx_ready pulses once at frame start.
2. Modes 1, 2 and 3 each: two back-to-back words 0x81 then 0x7E in one frame, tx_data sequence 0xF0, 0x0F -> RX gets 0x81 then 0x7E, MISO reads 0xF0 then 0x0F, exactly 2 tx_ready pulses per frame.
3. rx_ready=0, three words sent -> rx_data holds the first word and rx_overrun=1. clr_status then clears it, and rx_ready=1 delivers the held word.
4. tx_valid=0 throughout -> MISO reads 0x00 and tx_underrun=1. clr_status together with a new underrun event -> the flag stays 1.
5. cs_n deasserted after 5 bits, then a new frame sends 0x55 -> no rx_valid for the partial word, rx_data=0x55.
6. DATA_W=12, MSB_FIRST=0, mode 0. Send 0x9C3 -> rx_data=0x9C3. rst asserted mid-word -> all outputs return to 0 and the next frame works.
